// File: rtl/stack_pkg.sv
// Shared types for the operand-stack controller: error codes and FSM states.
package stack_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2,
        ERR_ILL  = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_ERR
    } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/response bundle between the main controller (master) and the stack controller (slave).
interface stack_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic              tos;
    logic [DATA_W-1:0] din;
    logic              err_clr;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              ready;
    logic              full;
    logic              empty;
    logic [SP_W-1:0]   sp;
    logic [1:0]        err_code;

    modport master (
        output push, pop, tos, din, err_clr,
        input  dout, dout_vld, ready, full, empty, sp, err_code
    );

    modport slave (
        input  push, pop, tos, din, err_clr,
        output dout, dout_vld, ready, full, empty, sp, err_code
    );

endinterface

// File: rtl/stack_ram.sv
// Stack storage: one write port and one synchronous read port; the array is never reset.
module stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: stack pointer, error lock-out FSM and registered pop/tos data.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input logic         clk,
    input logic         rst,
    stack_ctrl_if.slave bus
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state;
    state_e            state_nxt;
    err_e              err_q;
    err_e              err_nxt;
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_nxt;
    logic [SP_W-1:0]   sp_dec;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rdata;
    logic              dout_vld_q;
    logic              ready;
    logic              we;
    logic              re;
    logic              full;
    logic              empty;
    logic [1:0]        n_strb;

    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);
    assign sp_dec = sp_q - SP_W'(1);
    assign n_strb = 2'(bus.push) + 2'(bus.pop) + 2'(bus.tos);

    stack_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(sp_q[AW-1:0]),
        .wdata(bus.din),
        .re   (re),
        .raddr(sp_dec[AW-1:0]),
        .rdata(rdata)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        sp_nxt    = sp_q;
        ready     = 1'b1;
        we        = 1'b0;
        re        = 1'b0;
        unique case (state)
            ST_IDLE, ST_RD: begin
                state_nxt = ST_IDLE;
                if (n_strb > 2'd1) begin
                    err_nxt   = ERR_ILL;
                    state_nxt = ST_ERR;
                end else if (bus.push) begin
                    if (full) begin
                        err_nxt   = ERR_OVF;
                        state_nxt = ST_ERR;
                    end else begin
                        we     = 1'b1;
                        sp_nxt = sp_q + SP_W'(1);
                    end
                end else if (bus.pop || bus.tos) begin
                    if (empty) begin
                        err_nxt   = ERR_UNF;
                        state_nxt = ST_ERR;
                    end else begin
                        re        = 1'b1;
                        state_nxt = ST_RD;
                        if (bus.pop) begin
                            sp_nxt = sp_dec;
                        end
                    end
                end
            end
            ST_ERR: begin
                ready = 1'b0;
                if (bus.err_clr) begin
                    err_nxt   = ERR_NONE;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            err_q <= ERR_NONE;
            sp_q  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            sp_q  <= sp_nxt;
        end
    end

    // RAM read registered on the accepting edge; dout takes it one edge later while in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_vld_q <= (state == ST_RD);
            if (state == ST_RD) begin
                dout_q <= rdata;
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.ready    = ready;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.sp       = sp_q;
    assign bus.err_code = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_stack_ctrl;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stack_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue is the stack; a read result becomes visible one edge after it is taken.
    logic [DATA_W-1:0] q[$];
    int                m_err;
    bit                m_lock;
    bit                m_vld;
    bit                pend;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] pval;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_err  = 0;
            m_lock = 0;
            m_vld  = 0;
            pend   = 0;
            m_dout = '0;
        end else begin
            m_vld = pend;
            if (pend) m_dout = pval;
            pend = 0;
            if (m_lock) begin
                if (bus.err_clr) begin
                    m_lock = 0;
                    m_err  = 0;
                end
            end else if (int'(bus.push) + int'(bus.pop) + int'(bus.tos) > 1) begin
                m_err  = 3;
                m_lock = 1;
            end else if (bus.push) begin
                if (q.size() == DEPTH) begin
                    m_err  = 1;
                    m_lock = 1;
                end else begin
                    q.push_back(bus.din);
                end
            end else if (bus.pop || bus.tos) begin
                if (q.size() == 0) begin
                    m_err  = 2;
                    m_lock = 1;
                end else begin
                    pval = q[$];
                    pend = 1;
                    if (bus.pop) void'(q.pop_back());
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("sp",       int'(bus.sp),       q.size());
        chk("full",     int'(bus.full),     int'(q.size() == DEPTH));
        chk("empty",    int'(bus.empty),    int'(q.size() == 0));
        chk("ready",    int'(bus.ready),    int'(!m_lock));
        chk("err_code", int'(bus.err_code), m_err);
        chk("dout_vld", int'(bus.dout_vld), int'(m_vld));
        chk("dout",     int'(bus.dout),     int'(m_dout));
    end

    task automatic cmd(input bit p, input bit po, input bit t, input bit c, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.push    = p;
        bus.pop     = po;
        bus.tos     = t;
        bus.err_clr = c;
        bus.din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd(0, 0, 0, 0, '0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.err_clr = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.err_clr = 0; bus.din = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sp",    int'(bus.sp),       0);
        chk("rst_ready", int'(bus.ready),    1);
        chk("rst_dout",  int'(bus.dout),     0);
        chk("rst_vld",   int'(bus.dout_vld), 0);
        chk("rst_err",   int'(bus.err_code), 0);
        chk("rst_empty", int'(bus.empty),    1);
        @(negedge clk);
        rst = 1'b0;

        // LIFO order with back-to-back pops
        cmd(1, 0, 0, 0, 8'h11);
        cmd(1, 0, 0, 0, 8'h22);
        cmd(1, 0, 0, 0, 8'h33);
        chk("t1_sp3", int'(bus.sp), 3);
        cmd(0, 1, 0, 0, '0);
        cmd(0, 1, 0, 0, '0);
        chk("t1_d33", int'(bus.dout), 8'h33);
        chk("t1_v33", int'(bus.dout_vld), 1);
        cmd(0, 1, 0, 0, '0);
        chk("t1_d22", int'(bus.dout), 8'h22);
        idle();
        chk("t1_d11", int'(bus.dout), 8'h11);
        chk("t1_sp0", int'(bus.sp), 0);
        chk("t1_empty", int'(bus.empty), 1);
        idle();
        chk("t1_vld_drop", int'(bus.dout_vld), 0);
        chk("t1_hold", int'(bus.dout), 8'h11);

        // Overflow and clear
        for (int i = 0; i < DEPTH; i++) cmd(1, 0, 0, 0, 8'(i * 3 + 1));
        chk("t2_full", int'(bus.full), 1);
        cmd(1, 0, 0, 0, 8'hEE);
        chk("t2_err", int'(bus.err_code), 1);
        chk("t2_ready", int'(bus.ready), 0);
        chk("t2_sp", int'(bus.sp), DEPTH);
        cmd(0, 0, 0, 1, '0);
        chk("t2_clr_err", int'(bus.err_code), 0);
        chk("t2_clr_ready", int'(bus.ready), 1);
        cmd(0, 1, 0, 0, '0);
        idle();
        chk("t2_top", int'(bus.dout), (DEPTH - 1) * 3 + 1);
        reset_dut();

        // Underflow, push ignored while locked
        cmd(0, 1, 0, 0, '0);
        chk("t3_err", int'(bus.err_code), 2);
        chk("t3_ready", int'(bus.ready), 0);
        cmd(1, 0, 0, 0, 8'h44);
        chk("t3_sp", int'(bus.sp), 0);
        chk("t3_err_held", int'(bus.err_code), 2);
        cmd(0, 0, 0, 1, '0);
        chk("t3_clr", int'(bus.err_code), 0);

        // tos does not consume
        cmd(1, 0, 0, 0, 8'hA5);
        cmd(0, 0, 1, 0, '0);
        cmd(0, 0, 1, 0, '0);
        chk("t4_tos1", int'(bus.dout), 8'hA5);
        chk("t4_sp1", int'(bus.sp), 1);
        cmd(0, 1, 0, 0, '0);
        chk("t4_tos2", int'(bus.dout), 8'hA5);
        chk("t4_tos2_vld", int'(bus.dout_vld), 1);
        idle();
        chk("t4_pop", int'(bus.dout), 8'hA5);
        chk("t4_empty", int'(bus.empty), 1);

        // Illegal multi-strobe leaves contents intact
        cmd(1, 0, 0, 0, 8'h5A);
        cmd(1, 1, 0, 0, 8'hFF);
        chk("t5_err", int'(bus.err_code), 3);
        chk("t5_sp", int'(bus.sp), 1);
        cmd(0, 0, 0, 1, '0);
        cmd(0, 0, 1, 0, '0);
        idle();
        chk("t5_keep", int'(bus.dout), 8'h5A);

        // Async reset while a pop read is pending
        cmd(1, 0, 0, 0, 8'h77);
        cmd(0, 0, 1, 0, '0);
        cmd(0, 1, 0, 0, '0);
        chk("t6_pre_vld", int'(bus.dout_vld), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_vld", int'(bus.dout_vld), 0);
        chk("t6_dout", int'(bus.dout), 0);
        chk("t6_sp", int'(bus.sp), 0);
        chk("t6_ready", int'(bus.ready), 1);
        @(negedge clk);
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.err_clr = 0;
        rst = 1'b0;

        // Randomized traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int r;
            int push_w;
            @(negedge clk);
            r      = $urandom_range(0, 99);
            push_w = ((i / 150) % 2 == 0) ? 50 : 25;
            bus.push = 0; bus.pop = 0; bus.tos = 0; bus.err_clr = 0;
            bus.din  = DATA_W'($urandom);
            if (!bus.ready) begin
                bus.err_clr = ($urandom_range(0, 3) != 0);
            end else begin
                if (r < push_w) bus.push = 1;
                else if (r < 80) bus.pop = 1;
                else if (r < 90) bus.tos = 1;
                else if (r < 94) begin
                    case ($urandom_range(0, 3))
                        0: begin bus.push = 1; bus.pop = 1; end
                        1: begin bus.push = 1; bus.tos = 1; end
                        2: begin bus.pop = 1; bus.tos = 1; end
                        default: begin bus.push = 1; bus.pop = 1; bus.tos = 1; end
                    endcase
                end
                bus.err_clr = ($urandom_range(0, 19) == 0);
            end
        end
        @(negedge clk);
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.err_clr = 0;
        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
